// File: rtl/rvx10_div_pkg.sv
// Shared types and constants for the RVX10 M-extension divider.
package rvx10_div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/rvx10_divider_if.sv
// Request/response bundle between the EX stage and the divider.
interface rvx10_divider_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/rvx10_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, try to subtract.
module rvx10_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  import rvx10_div_pkg::*;

  logic [XLEN-1:0] shifted_s;
  logic [XLEN:0]   trial_s;

  // Restoring step; the extra MSB of the trial is the borrow.
  always_comb begin
    shifted_s = {rem_i[XLEN-2:0], quo_i[XLEN-1]};
    trial_s   = {1'b0, shifted_s} - {1'b0, divisor_i};
    if (!trial_s[XLEN]) begin
      rem_o = trial_s[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted_s;
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/rvx10_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU; XLEN+2 cycles per normal op,
// one cycle for divide-by-zero and signed overflow.
module rvx10_divider #(
  parameter int XLEN = 32
) (
  input logic            clk,
  input logic            reset,
  rvx10_divider_if.slave bus
);
  import rvx10_div_pkg::*;

  localparam int CNT_W = $clog2(XLEN);

  div_state_e       state_q;
  div_op_e          op_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  divisor_q;
  logic [XLEN-1:0]  result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  div_op_e          op_in_s;
  logic             in_signed_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [XLEN-1:0]  a_mag_s;
  logic [XLEN-1:0]  b_mag_s;
  logic             special_s;
  logic [XLEN-1:0]  special_res_s;
  logic [XLEN-1:0]  q_fix_s;
  logic [XLEN-1:0]  r_fix_s;
  logic [XLEN-1:0]  fix_res_s;
  logic [XLEN-1:0]  step_rem_s;
  logic [XLEN-1:0]  step_quo_s;
  logic [XLEN-1:0]  int_min_s;
  logic [XLEN-1:0]  all_ones_s;

  rvx10_div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem_s),
    .quo_o     (step_quo_s)
  );

  // Operand conditioning, special-case detection and final sign fix-up.
  always_comb begin
    int_min_s   = {1'b1, {(XLEN-1){1'b0}}};
    all_ones_s  = {XLEN{1'b1}};
    op_in_s     = div_op_e'(bus.op);
    in_signed_s = (op_in_s == DIV) || (op_in_s == REM);
    a_neg_s     = in_signed_s & bus.a[XLEN-1];
    b_neg_s     = in_signed_s & bus.b[XLEN-1];
    a_mag_s     = a_neg_s ? -bus.a : bus.a;
    b_mag_s     = b_neg_s ? -bus.b : bus.b;

    if (bus.b == {XLEN{1'b0}}) begin
      special_s     = 1'b1;
      special_res_s = bus.op[1] ? bus.a : all_ones_s;
    end else if (in_signed_s && (bus.a == int_min_s) && (bus.b == all_ones_s)) begin
      special_s     = 1'b1;
      special_res_s = bus.op[1] ? {XLEN{1'b0}} : int_min_s;
    end else begin
      special_s     = 1'b0;
      special_res_s = {XLEN{1'b0}};
    end

    // Sign flags are only ever set for signed ops, so no op check is needed here.
    q_fix_s   = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
    r_fix_s   = sign_a_q ? -rem_q : rem_q;
    fix_res_s = ((op_q == REM) || (op_q == REMU)) ? r_fix_s : q_fix_s;
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= DIV;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      rem_q     <= {XLEN{1'b0}};
      quo_q     <= {XLEN{1'b0}};
      divisor_q <= {XLEN{1'b0}};
      result_q  <= {XLEN{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q      <= op_in_s;
            sign_a_q  <= a_neg_s;
            sign_b_q  <= b_neg_s;
            quo_q     <= a_mag_s;
            divisor_q <= b_mag_s;
            rem_q     <= {XLEN{1'b0}};
            cnt_q     <= CNT_W'(XLEN - 1);
            if (special_s) begin
              result_q <= special_res_s;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              busy_q   <= 1'b1;
              state_q  <= RUN;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          rem_q <= step_rem_s;
          quo_q <= step_quo_s;
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        FIX: begin
          result_q <= fix_res_s;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule
